// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder
// Snoops a scanned 12-position 14-segment display bus, decodes each
// position's segment pattern to ASCII and publishes complete, in-order
// frames into a shadow buffer that is read combinationally.
module seg14_scan_decoder (
`ifdef USE_POWER_PINS
  inout  wire         vdd,
  inout  wire         vss,
`endif
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sel,
  input  logic [13:0] segm,
  input  logic [3:0]  rd_addr,
  output logic [6:0]  rd_data,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  output logic        unk_flag,
  output logic        seq_err,
  output logic        onehot_err
);

  typedef enum logic {SYNC, CAPTURE} state_t;

  localparam int unsigned NPOS = 12;

  // Stage S1 input registers
  logic [11:0] sel_reg;
  logic [13:0] segm_reg;

  // Control state
  state_t      state_reg, state_next;
  logic [3:0]  exp_reg, exp_next;
  logic        unk_frame_reg, unk_frame_next;
  logic [7:0]  frame_cnt_reg;
  logic        unk_flag_reg;
  logic        frame_valid_reg;
  logic        seq_err_reg, seq_err_next;
  logic        onehot_err_reg, onehot_err_next;

  // Decoded S1 sample
  logic [6:0]  char_c;
  logic        unk_c;
  logic [3:0]  k_c;
  logic        is_multi;
  logic        is_valid;

  // Write strobes shared by the per-position storage
  logic        wr_en;
  logic        frame_done;

  logic [6:0]  shadow_arr [NPOS];

  // Register the raw bus once before any decoding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_reg  <= '0;
      segm_reg <= '0;
    end else begin
      sel_reg  <= sel;
      segm_reg <= segm;
    end
  end

  // Segment pattern to ASCII; anything not in the table is '?' and unknown
  always_comb begin
    char_c = 7'h3F;
    unk_c  = 1'b0;
    case (segm_reg)
      14'b11101111000000: char_c = 7'h41;
      14'b11110000010010: char_c = 7'h44;
      14'b10011110000000: char_c = 7'h45;
      14'b10010000010010: char_c = 7'h49;
      14'b01101100100100: char_c = 7'h4E;
      14'b11001111000000: char_c = 7'h50;
      14'b11001111000100: char_c = 7'h52;
      14'b10110111000000: char_c = 7'h53;
      14'b00000000000000: char_c = 7'h20;
      default:            unk_c  = 1'b1;
    endcase
  end

  // Classify the select: a value with its lowest set bit cleared is
  // nonzero exactly when two or more bits were set
  always_comb begin
    is_multi = ((sel_reg & (sel_reg - 12'd1)) != 12'd0);
    is_valid = (sel_reg != 12'd0) && !is_multi;
    k_c      = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (sel_reg[i]) k_c = 4'(i);
    end
  end

  // Next-state logic: frame sequencing, error pulses, write strobes
  always_comb begin
    state_next      = state_reg;
    exp_next        = exp_reg;
    unk_frame_next  = unk_frame_reg;
    seq_err_next    = 1'b0;
    onehot_err_next = 1'b0;
    wr_en           = 1'b0;
    frame_done      = 1'b0;

    if (is_multi) begin
      onehot_err_next = 1'b1;
      state_next      = SYNC;
    end else if (is_valid) begin
      case (state_reg)
        SYNC: begin
          if (k_c == 4'd0) begin
            wr_en          = 1'b1;
            exp_next       = 4'd1;
            unk_frame_next = unk_c;
            state_next     = CAPTURE;
          end
        end
        CAPTURE: begin
          if (k_c == exp_reg) begin
            wr_en          = 1'b1;
            unk_frame_next = unk_frame_reg | unk_c;
            exp_next       = k_c + 4'd1;
            if (k_c == 4'd11) begin
              frame_done = 1'b1;
              exp_next   = 4'd0;
              state_next = SYNC;
            end
          end else begin
            seq_err_next = 1'b1;
            if (k_c == 4'd0) begin
              // Restart the frame; position 0 is written as a fresh start
              wr_en          = 1'b1;
              exp_next       = 4'd1;
              unk_frame_next = unk_c;
              state_next     = CAPTURE;
            end else begin
              exp_next   = 4'd0;
              state_next = SYNC;
            end
          end
        end
        default: state_next = SYNC;
      endcase
    end
  end

  // Control registers and published frame status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= SYNC;
      exp_reg         <= 4'd0;
      unk_frame_reg   <= 1'b0;
      frame_cnt_reg   <= 8'd0;
      unk_flag_reg    <= 1'b0;
      frame_valid_reg <= 1'b0;
      seq_err_reg     <= 1'b0;
      onehot_err_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      exp_reg         <= exp_next;
      unk_frame_reg   <= unk_frame_next;
      frame_valid_reg <= frame_done;
      seq_err_reg     <= seq_err_next;
      onehot_err_reg  <= onehot_err_next;
      if (frame_done) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
        unk_flag_reg  <= unk_frame_next;
      end
    end
  end

  // One capture entry and one shadow entry per display position
  generate
    for (genvar gi = 0; gi < NPOS; gi++) begin : g_pos
      logic [6:0] cap_reg;
      logic [6:0] shadow_reg;

      // Capture entry: written by an in-order (or restart) sample for this position
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cap_reg <= 7'h20;
        end else if (wr_en && (k_c == 4'(gi))) begin
          cap_reg <= char_c;
        end
      end

      // Shadow entry: loaded only when a full frame completes; the last
      // position comes straight from the decoder since it lands this edge
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shadow_reg <= 7'h20;
        end else if (frame_done) begin
          shadow_reg <= (gi == NPOS - 1) ? char_c : cap_reg;
        end
      end

      assign shadow_arr[gi] = shadow_reg;
    end
  endgenerate

  assign rd_data     = (rd_addr <= 4'd11) ? shadow_arr[rd_addr] : 7'h00;
  assign frame_valid = frame_valid_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign unk_flag    = unk_flag_reg;
  assign seq_err     = seq_err_reg;
  assign onehot_err  = onehot_err_reg;

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// tb_seg14_scan_decoder
// Directed scenarios plus randomized bus traffic, checked against a
// queue-based frame model of the display snooper.
module tb_seg14_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sel = '0;
  logic [13:0] segm = '0;
  logic [3:0]  rd_addr = '0;
  logic [6:0]  rd_data;
  logic        frame_valid;
  logic [7:0]  frame_cnt;
  logic        unk_flag;
  logic        seq_err;
  logic        onehot_err;
`ifdef USE_POWER_PINS
  wire vdd;
  wire vss;
`endif

  always #5 clk = ~clk;

  seg14_scan_decoder dut (
`ifdef USE_POWER_PINS
    .vdd         (vdd),
    .vss         (vss),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .segm        (segm),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_cnt   (frame_cnt),
    .unk_flag    (unk_flag),
    .seq_err     (seq_err),
    .onehot_err  (onehot_err)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int fv_seen = 0;

  // Reference model: completed shadow, frame count, unknown flag,
  // the partial frame as a queue, and pulses due after the next edge
  logic [6:0] m_shadow [12];
  logic [6:0] m_q [$];
  int         m_cnt;
  bit         m_unk;
  bit         p_fv, p_seq, p_oh;

  function automatic logic [13:0] pat(input byte c);
    case (c)
      "A": return 14'b11101111000000;
      "D": return 14'b11110000010010;
      "E": return 14'b10011110000000;
      "I": return 14'b10010000010010;
      "N": return 14'b01101100100100;
      "P": return 14'b11001111000000;
      "R": return 14'b11001111000100;
      "S": return 14'b10110111000000;
      " ": return 14'b00000000000000;
      default: return 14'b11111111111111;
    endcase
  endfunction

  function automatic logic [6:0] ref_decode(input logic [13:0] s);
    string known;
    known = "ADEINPRS ";
    for (int i = 0; i < known.len(); i++) begin
      if (pat(known[i]) == s) return 7'(known[i]);
    end
    return 7'h3F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 12; i++) m_shadow[i] = 7'h20;
    m_q.delete();
    m_cnt = 0;
    m_unk = 1'b0;
    p_fv = 1'b0; p_seq = 1'b0; p_oh = 1'b0;
  endtask

  task automatic model_step(input logic [11:0] s, input logic [13:0] g);
    int k;
    bit synced;
    logic [6:0] c;
    p_fv = 1'b0; p_seq = 1'b0; p_oh = 1'b0;
    if ($countones(s) > 1) begin
      p_oh = 1'b1;
      m_q.delete();
    end else if ($countones(s) == 1) begin
      k = 0;
      for (int i = 0; i < 12; i++) if (s[i]) k = i;
      c = ref_decode(g);
      synced = (m_q.size() > 0);
      if (synced && k == m_q.size()) begin
        m_q.push_back(c);
      end else if (k == 0) begin
        if (synced) p_seq = 1'b1;
        m_q.delete();
        m_q.push_back(c);
      end else if (synced) begin
        p_seq = 1'b1;
        m_q.delete();
      end
      if (m_q.size() == 12) begin
        m_unk = 1'b0;
        for (int i = 0; i < 12; i++) begin
          m_shadow[i] = m_q[i];
          if (m_q[i] == 7'h3F) m_unk = 1'b1;
        end
        m_cnt = (m_cnt + 1) % 256;
        p_fv = 1'b1;
        m_q.delete();
      end
    end
  endtask

  // One bus sample: drive on the falling edge, check just after the rising edge
  task automatic cycle(input logic [11:0] s, input logic [13:0] g);
    @(negedge clk);
    sel  = s;
    segm = g;
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1) fv_seen++;
    check("frame_valid", 32'(frame_valid), 32'(p_fv));
    check("seq_err", 32'(seq_err), 32'(p_seq));
    check("onehot_err", 32'(onehot_err), 32'(p_oh));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    check("unk_flag", 32'(unk_flag), 32'(m_unk));
    model_step(s, g);
  endtask

  task automatic send_word(input string w, input int first, input int last);
    for (int k = first; k <= last; k++) cycle(12'(1 << k), pat(w[k]));
  endtask

  // Read back the whole shadow; only called while sel is idle
  task automatic check_shadow();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check($sformatf("rd_data[%0d]", a), 32'(rd_data), (a < 12) ? 32'(m_shadow[a]) : 32'h0);
    end
  endtask

  task automatic do_reset(input logic [11:0] s, input logic [13:0] g);
    @(negedge clk);
    rst_n = 1'b0;
    sel   = s;
    segm  = g;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_seq_err", 32'(seq_err), 32'h0);
    check("rst_onehot_err", 32'(onehot_err), 32'h0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    check("rst_unk_flag", 32'(unk_flag), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sel   = '0;
    segm  = '0;
    @(posedge clk);
    #1;
    check_shadow();
  endtask

  string      word_a;
  string      word_b;
  logic [6:0] sd_exp [12];
  int         pos;
  int         r;
  logic [11:0] rs;
  logic [13:0] rg;

  initial begin
    word_a = "SERENDIPIA  ";
    word_b = "PRAISED  DEN";
    sd_exp = '{7'h53, 7'h45, 7'h52, 7'h45, 7'h4E, 7'h44, 7'h49, 7'h50, 7'h49, 7'h41, 7'h20, 7'h20};
    model_reset();

    // Reset state
    do_reset(12'h000, 14'h0);

    // Full frame "SERENDIPIA  "
    send_word(word_a, 0, 11);
    cycle(12'h000, 14'h0);
    cycle(12'h000, 14'h0);
    check_shadow();
    for (int a = 0; a < 12; a++) begin
      rd_addr = 4'(a);
      #1;
      check($sformatf("serendipia[%0d]", a), 32'(rd_data), 32'(sd_exp[a]));
    end
    check("serendipia_cnt", 32'(frame_cnt), 32'd1);

    // Capture starting at k=5: ignored until position 0
    send_word(word_b, 5, 11);
    send_word(word_b, 0, 11);
    cycle(12'h000, 14'h0);
    cycle(12'h000, 14'h0);
    check_shadow();

    // Skipped position: 0,1,2,4 with idles between
    cycle(12'h001, pat("S"));
    cycle(12'h000, 14'h0);
    cycle(12'h002, pat("E"));
    cycle(12'h004, pat("R"));
    cycle(12'h010, pat("N"));
    cycle(12'h000, 14'h0);
    cycle(12'h000, 14'h0);
    check_shadow();

    // Multiple selects mid-frame; remaining positions must be ignored
    send_word(word_a, 0, 3);
    cycle(12'h003, pat("A"));
    send_word(word_a, 4, 11);
    cycle(12'h000, 14'h0);
    send_word(word_a, 0, 11);
    cycle(12'h000, 14'h0);
    cycle(12'h000, 14'h0);
    check_shadow();

    // Unknown pattern at k=3, then a clean frame
    send_word(word_b, 0, 2);
    cycle(12'h008, 14'b11111111111111);
    send_word(word_b, 4, 11);
    cycle(12'h000, 14'h0);
    cycle(12'h000, 14'h0);
    check_shadow();
    check("unk_after_bad", 32'(unk_flag), 32'h1);
    send_word(word_a, 0, 11);
    cycle(12'h000, 14'h0);
    cycle(12'h000, 14'h0);
    check("unk_after_clean", 32'(unk_flag), 32'h0);

    // 256 back-to-back frames from reset: count wraps to zero
    do_reset(12'h000, 14'h0);
    fv_seen = 0;
    for (int f = 0; f < 256; f++) send_word((f % 2) ? word_a : word_b, 0, 11);
    cycle(12'h000, 14'h0);
    cycle(12'h000, 14'h0);
    check("wrap_cnt", 32'(frame_cnt), 32'h0);
    check("wrap_pulses", 32'(fv_seen), 32'd256);
    check_shadow();

    // Reset at k=6 mid-frame, then positions 1..11 must be ignored
    send_word(word_a, 0, 5);
    do_reset(12'h040, pat("I"));
    send_word(word_b, 1, 11);
    cycle(12'h000, 14'h0);
    check_shadow();
    send_word(word_b, 0, 11);
    cycle(12'h000, 14'h0);
    cycle(12'h000, 14'h0);
    check_shadow();

    // Randomized traffic: mostly in-order scanning with idles, jumps,
    // multi-selects and occasional unknown patterns
    pos = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        rs = 12'(1 << pos);
        pos = (pos + 1) % 12;
      end else if (r < 82) begin
        rs = 12'h000;
      end else if (r < 92) begin
        rs = 12'(1 << $urandom_range(0, 11));
      end else begin
        rs = 12'(1 << $urandom_range(0, 11)) | 12'(1 << $urandom_range(0, 11));
      end
      r = $urandom_range(0, 99);
      if (r < 85) rg = pat(word_a[$urandom_range(0, 11)]);
      else if (r < 92) rg = pat(word_b[$urandom_range(0, 11)]);
      else rg = 14'($urandom);
      cycle(rs, rg);
      if (n % 200 == 199) begin
        cycle(12'h000, 14'h0);
        check_shadow();
      end
    end
    cycle(12'h000, 14'h0);
    check_shadow();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg14_scan_decoder.md
SEG14_SCAN_DECODER -- requirements
Module: seg14_scan_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have ports vdd, vss, inout, present only under USE_POWER_PINS: supply and ground.
REQ-004 SHALL have port sel, input, 12 bits: digit select from the scanned display bus, one-hot, bit k = position k.
REQ-005 SHALL have port segm, input, 14 bits: segment pattern for the selected position.
REQ-006 SHALL have port rd_addr, input, 4 bits: read index into the completed-frame buffer, 0..11.
REQ-007 SHALL have port rd_data, output, 7 bits: ASCII code at rd_addr; combinational from shadow; 0x00 if rd_addr > 11.
REQ-008 SHALL have port frame_valid, output, 1 bit: one-cycle pulse on frame completion.
REQ-009 SHALL have port frame_cnt, output, 8 bits: completed-frame count, wraps 255 -> 0.
REQ-010 SHALL have port unk_flag, output, 1 bit: the last completed frame contained at least one unknown pattern.
REQ-011 SHALL have port seq_err, output, 1 bit: one-cycle pulse on an out-of-order position.
REQ-012 SHALL have port onehot_err, output, 1 bit: one-cycle pulse on a sel value with more than one bit set.

Function
REQ-013 SHALL register sel and segm once (stage S1) before any decoding.
REQ-014 SHALL decode the S1 segm value to ASCII using this table:
- 11101111000000 = 'A' (0x41)
- 11110000010010 = 'D' (0x44)
- 10011110000000 = 'E' (0x45)
- 10010000010010 = 'I' (0x49)
- 01101100100100 = 'N' (0x4E)
- 11001111000000 = 'P' (0x50)
- 11001111000100 = 'R' (0x52)
- 10110111000000 = 'S' (0x53)
- 00000000000000 = ' ' (0x20)
- any other value = '?' (0x3F), and sets the frame's unknown bit.
REQ-015 SHALL classify S1 sel as one of:
- IDLE: zero; ignored, no state change.
- VALID: exactly one bit set; index k = 0..11.
- MULTI: two or more bits set.
REQ-016 SHALL implement an FSM with states SYNC and CAPTURE and an expected-index register exp (0..11).
REQ-017 In SYNC, SHALL ignore VALID samples with k != 0; on k == 0, SHALL write buf[0], set exp = 1, clear the frame unknown bit (then apply the current sample), and enter CAPTURE.
REQ-018 In CAPTURE, on VALID with k == exp, SHALL write buf[k] with the decoded char and set exp = k+1.
REQ-019 In CAPTURE, on VALID with k != exp, SHALL pulse seq_err.
- If k == 0, SHALL restart the frame as in REQ-017 and stay in CAPTURE.
- Otherwise SHALL go to SYNC.
REQ-020 On MULTI in any state, SHALL pulse onehot_err, write nothing, and go to SYNC.
REQ-021 On an in-order write with k == 11, SHALL do all of the following at the same edge:
- copy buf[0..10] plus the new char into the shadow buffer;
- update unk_flag from the frame unknown bit;
- increment frame_cnt;
- go to SYNC.
frame_valid SHALL be high for exactly the following cycle.
REQ-022 Latency SHALL be:
- sample edge N into S1;
- buf write at edge N+1;
- for k == 11, shadow, frame_cnt and unk_flag update at edge N+1, with frame_valid high during cycle N+1..N+2.
REQ-023 seq_err and onehot_err SHALL assert in the same cycle a buf write would have occurred (edge N+1).
REQ-024 Partial frames SHALL never alter shadow, frame_cnt or unk_flag.
REQ-025 rd_data SHALL reflect the shadow buffer only; a capture in progress SHALL NOT be visible.
REQ-026 IDLE cycles between positions SHALL be permitted without error.
REQ-027 Back-to-back frames (k = 11 followed directly by k = 0) SHALL be captured without a lost frame.

Reset
REQ-028 While rst_n is low at a clock edge, SHALL set:
- S1 to zero;
- FSM to SYNC, exp to 0;
- all buf and shadow entries to 0x20;
- frame_cnt to 0;
- unk_flag, frame_valid, seq_err and onehot_err to 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first post-reset frame SHALL require k == 0 first.
REQ-030 The first sample after rst_n rises SHALL be taken at the next edge.

Verification
REQ-031 Bench SHALL cover these directed scenarios:
- 12 consecutive positions k = 0..11 carrying patterns for "SERENDIPIA  " -> one frame_valid pulse 2 cycles after the k = 11 sample; rd_data for addr 0..11 = 53 45 52 45 4E 44 49 50 49 41 20 20 hex; frame_cnt = 1; unk_flag = 0.
- Capture starting at k = 5, then a full 0..11 sweep -> k = 5..11 ignored, no seq_err, exactly one frame.
- Positions 0,1,2,4 -> seq_err pulse at k = 4; FSM in SYNC; shadow unchanged; frame_cnt unchanged.
- sel = 000000000011 mid-frame -> onehot_err pulse; no frame until the next full 0..11 sweep.
- Frame with segm = 11111111111111 at k = 3 -> rd_data[3] = 0x3F and unk_flag = 1; the next clean frame clears unk_flag to 0.
- 256 back-to-back frames -> frame_cnt wraps to 0, 256 frame_valid pulses; rst_n low at k = 6 -> all outputs at reset values, shadow all 0x20.
